router_pkt_reader: RTL

- Destination-side client for one output port of the 1x3 router; drains the port's output FIFO through its vld_out/read_enb/data_out interface.
- Reassembles each packet (header, payload, parity), streams payload bytes out and checks parity, destination address and stall timeout.
- Used as the synthesizable sink in system tests and as the reference consumer for each router port.

---
 rtl/router_pkt_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/router_pkt_reader.sv
// Destination-side client for one router output port: drains the port FIFO,
// reassembles header/payload/parity, streams payload and reports packet status.
module router_pkt_reader #(
  parameter logic [1:0] PORT_ID   = 2'd0,
  parameter int         START_DLY = 2,
  parameter int         STALL_MAX = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  output logic       read_enb,
  output logic       pay_valid,
  output logic [7:0] pay_data,
  output logic [5:0] rx_len,
  output logic [1:0] rx_addr,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [1:0] err_type,
  output logic       busy,
  output logic [7:0] pkt_cnt,
  output logic [7:0] err_cnt
);

  localparam int DLY_W   = (START_DLY > 1) ? $clog2(START_DLY) : 1;
  localparam int STALL_W = $clog2(STALL_MAX + 1);
  localparam logic [DLY_W-1:0]   DLY_LAST   = DLY_W'((START_DLY > 0) ? START_DLY - 1 : 0);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

  typedef enum logic [1:0] {IDLE, WAIT, READ, CHECK} state_t;
  state_t state_reg, state_next;

  logic [DLY_W-1:0]   dly_cnt_reg;
  logic [STALL_W-1:0] stall_cnt_reg;
  logic [6:0]         issue_cnt_reg, rx_cnt_reg;
  logic               rd_flag_reg;
  logic [7:0]         acc_reg;
  logic [5:0]         rx_len_reg;
  logic [1:0]         rx_addr_reg;
  logic               err_flag_reg;
  logic [1:0]         err_type_reg;
  logic [7:0]         pkt_cnt_reg, err_cnt_reg;

  logic       hdr_seen, short_of_limit, rd_go, stall_hit;
  logic       cap, cap_hdr, cap_par, cap_pay, addr_bad, par_bad;
  logic [6:0] par_idx, issue_lim;

  // Until the header lands only header+one more byte may be in flight, which
  // also covers the len=0 case where the second byte is already parity.
  assign hdr_seen       = (rx_cnt_reg != 7'd0);
  assign par_idx        = {1'b0, rx_len_reg} + 7'd1;
  assign issue_lim      = hdr_seen ? (par_idx + 7'd1) : 7'd2;
  assign short_of_limit = (issue_cnt_reg < issue_lim);
  assign rd_go          = (state_reg == READ) && vld_out && short_of_limit;
  assign stall_hit      = (state_reg == READ) && !vld_out && short_of_limit &&
                          (stall_cnt_reg == STALL_LAST);

  assign cap      = (state_reg == READ) && rd_flag_reg;
  assign cap_hdr  = cap && !hdr_seen;
  assign cap_par  = cap && hdr_seen && (rx_cnt_reg == par_idx);
  assign cap_pay  = cap && hdr_seen && !cap_par;
  assign addr_bad = (rx_addr_reg != PORT_ID);
  assign par_bad  = (data_out != acc_reg);

  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable && vld_out) state_next = (START_DLY == 0) ? READ : WAIT;
      WAIT:    if (dly_cnt_reg == DLY_LAST) state_next = READ;
      READ:    if (stall_hit || cap_par) state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read_enb  = rd_go;
    pay_valid = cap_pay;
    pay_data  = cap_pay ? data_out : 8'h00;
    pkt_done  = (state_reg == CHECK);
    pkt_err   = (state_reg == CHECK) && err_flag_reg;
    busy      = (state_reg != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dly_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
      issue_cnt_reg <= '0;
      rx_cnt_reg    <= '0;
      rd_flag_reg   <= 1'b0;
      acc_reg       <= '0;
      rx_len_reg    <= '0;
      rx_addr_reg   <= '0;
      err_flag_reg  <= 1'b0;
      err_type_reg  <= '0;
      pkt_cnt_reg   <= '0;
      err_cnt_reg   <= '0;
    end else begin
      rd_flag_reg <= rd_go;
      case (state_reg)
        IDLE: begin
          dly_cnt_reg   <= '0;
          stall_cnt_reg <= '0;
          issue_cnt_reg <= '0;
          rx_cnt_reg    <= '0;
          acc_reg       <= '0;
        end
        WAIT: dly_cnt_reg <= dly_cnt_reg + 1'b1;
        READ: begin
          if (rd_go) issue_cnt_reg <= issue_cnt_reg + 7'd1;
          if (rd_go)                           stall_cnt_reg <= '0;
          else if (!vld_out && short_of_limit) stall_cnt_reg <= stall_cnt_reg + 1'b1;
          if (cap) rx_cnt_reg <= rx_cnt_reg + 7'd1;
          if (cap_hdr) begin
            rx_len_reg  <= data_out[7:2];
            rx_addr_reg <= data_out[1:0];
            acc_reg     <= data_out;
          end
          if (cap_pay) acc_reg <= acc_reg ^ data_out;
          // Status is resolved on the way into CHECK so it is valid alongside pkt_done.
          if (stall_hit) begin
            err_flag_reg <= 1'b1;
            err_type_reg <= 2'd2;
          end else if (cap_par) begin
            err_flag_reg <= addr_bad | par_bad;
            err_type_reg <= addr_bad ? 2'd1 : 2'd0;
          end
        end
        CHECK: begin
          if (err_flag_reg) begin
            if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
          end else begin
            if (pkt_cnt_reg != 8'hFF) pkt_cnt_reg <= pkt_cnt_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_len   = rx_len_reg;
  assign rx_addr  = rx_addr_reg;
  assign err_type = err_type_reg;
  assign pkt_cnt  = pkt_cnt_reg;
  assign err_cnt  = err_cnt_reg;

endmodule
